// File: rtl/reg_serializer_if.sv
// Load/serial-stream bundle for reg_serializer: parallel load handshake in,
// one-bit valid/ready stream out, plus status.
interface reg_serializer_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] d;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_ready;
   logic             last;
   logic             busy;

   modport master (
      output load, d, sout_ready,
      input  ready, sout, sout_valid, last, busy
   );

   modport slave (
      input  load, d, sout_ready,
      output ready, sout, sout_valid, last, busy
   );
endinterface

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out readout: captures a WIDTH-bit word on load/ready and
// streams it one bit per accepted beat, reloading on the last beat with no bubble.
module reg_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   reg_serializer_if.slave  bus
);
   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_w, ready_w, sout_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      last_w  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
      ready_w = (state_q == IDLE) || (last_w && bus.sout_ready);
      sout_w  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               shreg_d = bus.d;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sout_w = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            if (bus.sout_ready) begin
               if (!last_w) begin
                  // Zero-fill shift toward whichever end drives sout.
                  shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                  cnt_d   = cnt_q + CW'(1);
               end else if (bus.load) begin
                  shreg_d = bus.d;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
                  shreg_d = '0;
                  cnt_d   = '0;
               end
            end
         end
      endcase
   end

   assign bus.ready      = ready_w;
   assign bus.last       = last_w;
   assign bus.sout       = sout_w;
   assign bus.sout_valid = (state_q == SHIFT);
   assign bus.busy       = (state_q == SHIFT);
endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: MSB- and LSB-first instances share stimulus and are
// checked against per-word bit queues, directed tables and hand sequences.
module tb_reg_serializer;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_serializer_if #(.WIDTH(W)) bm ();
   reg_serializer_if #(.WIDTH(W)) bl ();

   reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
   reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));

   typedef struct {
      bit         rst;
      bit         ld;
      logic [3:0] d;
      bit         sr;
      bit         ev;  // expected sout_valid (and busy)
      bit         es;
      bit         el;
      bit         er;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   bit   model_ok = 1'b0;
   bit   qm[$];
   bit   ql[$];
   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle, compare against the queue models (and optionally
   // explicit expectations for the MSB instance), then advance the model.
   task automatic step(input bit r, input bit ld, input logic [3:0] dd, input bit sr,
                       input bit use_exp, input bit ev, input bit es, input bit el,
                       input bit er, input string nm);
      bit rm, rl;
      @(negedge clk);
      rst = r; bm.load = ld; bm.d = dd; bm.sout_ready = sr;
      bl.load = ld; bl.d = dd; bl.sout_ready = sr;
      #1;
      if (model_ok) begin
         chk({nm, ".m_valid"}, bm.sout_valid, qm.size() > 0);
         chk({nm, ".m_busy"},  bm.busy,       qm.size() > 0);
         chk({nm, ".m_sout"},  bm.sout,       (qm.size() > 0) ? qm[0] : 1'b0);
         chk({nm, ".m_last"},  bm.last,       qm.size() == 1);
         chk({nm, ".m_ready"}, bm.ready,      (qm.size() == 0) || (qm.size() == 1 && sr));
         chk({nm, ".l_valid"}, bl.sout_valid, ql.size() > 0);
         chk({nm, ".l_busy"},  bl.busy,       ql.size() > 0);
         chk({nm, ".l_sout"},  bl.sout,       (ql.size() > 0) ? ql[0] : 1'b0);
         chk({nm, ".l_last"},  bl.last,       ql.size() == 1);
         chk({nm, ".l_ready"}, bl.ready,      (ql.size() == 0) || (ql.size() == 1 && sr));
      end
      if (use_exp) begin
         chk({nm, ".valid"}, bm.sout_valid, ev);
         chk({nm, ".busy"},  bm.busy,       ev);
         chk({nm, ".sout"},  bm.sout,       es);
         chk({nm, ".last"},  bm.last,       el);
         chk({nm, ".ready"}, bm.ready,      er);
      end
      rm = (qm.size() == 0) || (qm.size() == 1 && sr);
      rl = (ql.size() == 0) || (ql.size() == 1 && sr);
      if (r) begin
         qm.delete();
         ql.delete();
      end else begin
         if (qm.size() > 0 && sr) void'(qm.pop_front());
         if (ql.size() > 0 && sr) void'(ql.pop_front());
         if (ld && rm) for (int i = W - 1; i >= 0; i--) qm.push_back(dd[i]);
         if (ld && rl) for (int i = 0; i < W; i++) ql.push_back(dd[i]);
      end
      @(posedge clk);
      if (r) model_ok = 1'b1;
   endtask

   initial begin
      int nvalid;
      logic [3:0] lsb12;

      // Tests 1, 3 and 2 as one continuous vector table (MSB-first view).
      tbl[0]  = '{0, 1, 4'd5,  1, 0, 0, 0, 1};
      tbl[1]  = '{0, 0, 4'd0,  1, 1, 0, 0, 0};
      tbl[2]  = '{0, 0, 4'd0,  1, 1, 1, 0, 0};
      tbl[3]  = '{0, 0, 4'd0,  1, 1, 0, 0, 0};
      tbl[4]  = '{0, 1, 4'd12, 1, 1, 1, 1, 1};
      tbl[5]  = '{0, 0, 4'd0,  1, 1, 1, 0, 0};
      tbl[6]  = '{0, 0, 4'd0,  1, 1, 1, 0, 0};
      tbl[7]  = '{0, 0, 4'd0,  1, 1, 0, 0, 0};
      tbl[8]  = '{0, 0, 4'd0,  1, 1, 0, 1, 1};
      tbl[9]  = '{0, 0, 4'd0,  1, 0, 0, 0, 1};
      tbl[10] = '{0, 1, 4'd5,  1, 0, 0, 0, 1};
      tbl[11] = '{0, 0, 4'd0,  1, 1, 0, 0, 0};
      tbl[12] = '{0, 1, 4'd9,  1, 1, 1, 0, 0};
      tbl[13] = '{0, 0, 4'd0,  1, 1, 0, 0, 0};
      tbl[14] = '{0, 0, 4'd0,  1, 1, 1, 1, 1};
      tbl[15] = '{0, 0, 4'd0,  1, 0, 0, 0, 1};

      rst = 1'b1;
      bm.load = 1'b0; bm.d = '0; bm.sout_ready = 1'b0;
      bl.load = 1'b0; bl.d = '0; bl.sout_ready = 1'b0;

      // Reset, with load asserted to show reset has priority.
      step(1, 1, 4'd7, 1, 0, 0, 0, 0, 0, "rst");
      step(0, 0, 4'd0, 1, 1, 0, 0, 0, 1, "rst_state");

      for (int i = 0; i < 16; i++)
         step(tbl[i].rst, tbl[i].ld, tbl[i].d, tbl[i].sr, 1,
              tbl[i].ev, tbl[i].es, tbl[i].el, tbl[i].er, $sformatf("tbl%0d", i));

      // Backpressure: 3 stalled cycles on the first bit of 12.
      nvalid = 0;
      step(0, 1, 4'd12, 1, 1, 0, 0, 0, 1, "bp_load");
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 4'd0, 0, 1, 1, 1, 0, 0, "bp_stall");
         nvalid += int'(bm.sout_valid);
      end
      step(0, 0, 4'd0, 1, 1, 1, 1, 0, 0, "bp_b0"); nvalid += int'(bm.sout_valid);
      step(0, 0, 4'd0, 1, 1, 1, 1, 0, 0, "bp_b1"); nvalid += int'(bm.sout_valid);
      step(0, 0, 4'd0, 1, 1, 1, 0, 0, 0, "bp_b2"); nvalid += int'(bm.sout_valid);
      step(0, 0, 4'd0, 1, 1, 1, 0, 1, 1, "bp_b3"); nvalid += int'(bm.sout_valid);
      step(0, 0, 4'd0, 1, 1, 0, 0, 0, 1, "bp_idle"); nvalid += int'(bm.sout_valid);
      chk("bp_valid_cycles", nvalid, 7);

      // Reset mid-word after bits 1,0 of 9.
      step(0, 1, 4'd9, 1, 1, 0, 0, 0, 1, "rm_load");
      step(0, 0, 4'd0, 1, 1, 1, 1, 0, 0, "rm_b0");
      step(0, 0, 4'd0, 1, 1, 1, 0, 0, 0, "rm_b1");
      step(1, 0, 4'd0, 1, 0, 0, 0, 0, 0, "rm_rst");
      step(0, 1, 4'd5, 1, 1, 0, 0, 0, 1, "rm_after");
      step(0, 0, 4'd0, 1, 1, 1, 0, 0, 0, "rm_n0");
      step(0, 0, 4'd0, 1, 1, 1, 1, 0, 0, "rm_n1");
      step(0, 0, 4'd0, 1, 1, 1, 0, 0, 0, "rm_n2");
      step(0, 0, 4'd0, 1, 1, 1, 1, 1, 1, "rm_n3");

      // LSB-first instance on d=12: expect 0,0,1,1.
      lsb12 = 4'b1100;
      step(0, 1, 4'd12, 1, 0, 0, 0, 0, 0, "lsb_load");
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 4'd0, 1, 0, 0, 0, 0, 0, "lsb_bit");
         chk($sformatf("lsb_sout%0d", i), bl.sout, lsb12[i]);
         chk($sformatf("lsb_last%0d", i), bl.last, i == 3);
         chk($sformatf("lsb_valid%0d", i), bl.sout_valid, 1'b1);
      end
      step(0, 0, 4'd0, 1, 0, 0, 0, 0, 0, "lsb_idle");
      chk("lsb_idle_valid", bl.sout_valid, 1'b0);

      // Randomized traffic against the queue models.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
              4'($urandom), $urandom_range(0, 3) != 0, 0, 0, 0, 0, 0, "rnd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
